multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I subset core. It sequences the shared ALU, register file, instruction register and unified memory port through the fetch, decode, execute, memory and writeback steps. It decodes opcode/funct fields held in the IR into per-cycle datapath strobes and mux selects; the immediate generator and ALU stay combinational under its control. Supported instructions are R-type ALU, I-type ALU (addi etc.), lw, sw, beq, bne and blt.

## Interface
- TRAP_ON_ILLEGAL, 1, 1: illegal instruction enters TRAP; 0: illegal instruction retires as a NOP.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2 from ALU compare.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write (valid only with mem_req).
- mem_addr_sel  out  1  0 = PC, 1 = ALU-out register.
- ir_we  out  1  latch instruction and old PC.
- pc_we  out  1  PC write enable.
- pc_sel  out  1  0 = ALU result (PC+4), 1 = branch target adder.
- alu_a_sel  out  1  0 = PC, 1 = rs1.
- alu_b_sel  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA.
- alu_out_we  out  1  latch the ALU-out register.
- reg_we  out  1  register-file write.
- wb_sel  out  1  0 = ALU-out, 1 = memory data register.
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction.
- illegal  out  1  high in TRAP.
- state_dbg  out  3  current state encoding.

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, BRANCH = 5, TRAP = 7.
- Every output is 0 unless listed under the current state. Outputs are combinational in the state and inputs.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0, alu_a_sel = 0, alu_b_sel = 2, alu_ctrl = ADD.
  - Stay in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_we = 1, pc_we = 1, pc_sel = 0, then go to DECODE.
- DECODE: register-file read cycle. Classify the opcode:
  - 0110011 or 0010011 → EXEC.
  - 0000011 or 0100011 → EXEC.
  - 1100011 with funct3 ∈ {000, 001, 100} → BRANCH.
  - Any other opcode, a branch with another funct3, or funct3 = 011 on an ALU opcode → illegal.
  - Illegal with TRAP_ON_ILLEGAL = 1 → TRAP. With TRAP_ON_ILLEGAL = 0: instr_done = 1, go to FETCH.
- EXEC: alu_a_sel = 1 and alu_out_we = 1 in all cases.
  - R-type: alu_b_sel = 0, then WB.
  - I-ALU: alu_b_sel = 1, then WB.
  - lw/sw: alu_b_sel = 1, alu_ctrl = ADD, then MEM.
- ALU mapping by funct3:
  - 000: ADD; SUB only when R-type and funct7_5 = 1.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL.
  - 101: SRL, or SRA when funct7_5 = 1 (both R and I).
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for sw. Hold the state until mem_ready.
  - lw on mem_ready → WB.
  - sw on mem_ready → instr_done = 1, go to FETCH.
- WB: reg_we = 1, wb_sel = 1 for lw and 0 otherwise, instr_done = 1, go to FETCH.
- BRANCH: alu_a_sel = 1, alu_b_sel = 0, alu_ctrl = SUB, instr_done = 1, go to FETCH.
  - Taken when: beq and alu_zero; bne and !alu_zero; blt and alu_lt.
  - If taken: pc_we = 1, pc_sel = 1.
- TRAP: illegal = 1, all other outputs 0, state held until rst.
- mem_ready is ignored outside FETCH and MEM.

## Timing
- Reset:
  - rst = 1 forces the state to FETCH asynchronously.
  - While rst = 1, all outputs are 0 (mem_req is gated by rst) and state_dbg = 0.
  - First request is issued in the first cycle after rst falls.
- Reset mid-operation, including mid-MEM or in TRAP: mem_req and reg_we drop in the same cycle rst rises. No write strobe is issued after rst.
- Cycle counts with zero-wait memory (mem_ready high in the request cycle):
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles, taken or not.
- Each memory wait cycle adds 1 cycle. All request outputs stay stable while waiting.
- instr_done pulses exactly once per retired instruction. It never pulses in TRAP.
- pc_we asserts at most twice per instruction: FETCH, plus BRANCH if taken.

## Test plan
- Reset release, mem_ready = 1 constantly, addi (opcode 0010011, funct3 000) → states 0,1,2,4. alu_b_sel = 1 in EXEC. reg_we = 1, wb_sel = 0 in WB. instr_done in cycle 4.
- lw with mem_ready low for 3 cycles in both FETCH and MEM → 11 cycles total. mem_req held steady. mem_addr_sel = 1, mem_we = 0 in MEM. wb_sel = 1 in WB.
- sw → MEM with mem_we = 1, then FETCH. reg_we never asserts.
- beq with alu_zero = 1 → pc_we = 1, pc_sel = 1 in BRANCH. bne with alu_zero = 1 → no pc_we in BRANCH. blt with alu_lt = 1 → taken.
- R-type funct3 000 with funct7_5 = 1 → alu_ctrl = 1. funct3 101 with funct7_5 = 1 → alu_ctrl = 8.
- Opcode 1101111 → TRAP with illegal = 1 held through 10 cycles. With TRAP_ON_ILLEGAL = 0 → instr_done, back to FETCH. rst pulse mid-MEM → mem_req = 0 immediately, then restart in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core: sequences fetch, decode,
// execute, memory and writeback, and decodes the IR opcode/funct fields into
// per-cycle datapath strobes and mux selects.
module multicycle_ctrl #(
  parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       alu_out_we,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  // funct3/funct7 to ALU operation; SUB exists only for R-type, while the
  // arithmetic shift is selected by IR[30] for both R and I forms.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic f7,
                                         input logic rtype);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (rtype && f7) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b010:  op = ALU_SLT;
      3'b001:  op = ALU_SLL;
      3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_t state, nxt;

  logic is_rtype, is_ialu, is_load, is_store, is_branch;
  logic br_ok, legal, br_taken;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c, pc_sel_c;
  logic       alu_a_sel_c, alu_out_we_c, reg_we_c, wb_sel_c, instr_done_c;
  logic       illegal_c;
  logic [1:0] alu_b_sel_c;
  logic [3:0] alu_ctrl_c;

  // The IR is stable from DECODE until the next FETCH, so the instruction
  // class is re-derived from it in every state rather than registered.
  always_comb begin
    is_rtype  = (opcode == OP_R);
    is_ialu   = (opcode == OP_I);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_branch = (opcode == OP_BRANCH);
    br_ok     = is_branch &&
                (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100);
    legal     = ((is_rtype || is_ialu) && funct3 != 3'b011) ||
                is_load || is_store || br_ok;
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      default: br_taken = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    nxt            = state;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = 1'b0;
    alu_a_sel_c    = 1'b0;
    alu_b_sel_c    = 2'd0;
    alu_ctrl_c     = ALU_ADD;
    alu_out_we_c   = 1'b0;
    reg_we_c       = 1'b0;
    wb_sel_c       = 1'b0;
    instr_done_c   = 1'b0;
    illegal_c      = 1'b0;
    case (state)
      S_FETCH: begin
        // PC + 4 is formed on the ALU while the instruction is read.
        mem_req_c   = 1'b1;
        alu_b_sel_c = 2'd2;
        alu_ctrl_c  = ALU_ADD;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          if (TRAP_ON_ILLEGAL) begin
            nxt = S_TRAP;
          end else begin
            instr_done_c = 1'b1;
            nxt          = S_FETCH;
          end
        end else if (is_branch) begin
          nxt = S_BRANCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel_c  = 1'b1;
        alu_out_we_c = 1'b1;
        if (is_load || is_store) begin
          alu_b_sel_c = 2'd1;
          alu_ctrl_c  = ALU_ADD;
          nxt         = S_MEM;
        end else begin
          alu_b_sel_c = is_rtype ? 2'd0 : 2'd1;
          alu_ctrl_c  = alu_map(funct3, funct7_5, is_rtype);
          nxt         = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = is_store;
        if (mem_ready) begin
          if (is_store) begin
            instr_done_c = 1'b1;
            nxt          = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        wb_sel_c     = is_load;
        instr_done_c = 1'b1;
        nxt          = S_FETCH;
      end
      S_BRANCH: begin
        // The compare runs on the ALU; the target comes from the branch adder.
        alu_a_sel_c  = 1'b1;
        alu_b_sel_c  = 2'd0;
        alu_ctrl_c   = ALU_SUB;
        instr_done_c = 1'b1;
        if (br_taken) begin
          pc_we_c  = 1'b1;
          pc_sel_c = 1'b1;
        end
        nxt = S_FETCH;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase
  end

  // Reset gates every output so no request or write strobe escapes while
  // the asynchronous reset is asserted.
  assign mem_req      = mem_req_c      & ~rst;
  assign mem_we       = mem_we_c       & ~rst;
  assign mem_addr_sel = mem_addr_sel_c & ~rst;
  assign ir_we        = ir_we_c        & ~rst;
  assign pc_we        = pc_we_c        & ~rst;
  assign pc_sel       = pc_sel_c       & ~rst;
  assign alu_a_sel    = alu_a_sel_c    & ~rst;
  assign alu_b_sel    = rst ? 2'd0 : alu_b_sel_c;
  assign alu_ctrl     = rst ? 4'd0 : alu_ctrl_c;
  assign alu_out_we   = alu_out_we_c   & ~rst;
  assign reg_we       = reg_we_c       & ~rst;
  assign wb_sel       = wb_sel_c       & ~rst;
  assign instr_done   = instr_done_c   & ~rst;
  assign illegal      = illegal_c      & ~rst;
  assign state_dbg    = rst ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected output vectors are queued
// with the stimulus and compared against two instances (trap / NOP on illegal).
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       mas;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic       as;
    logic [1:0] bs;
    logic [3:0] ac;
    logic       aow;
    logic       rw;
    logic       wbs;
    logic       dn;
    logic       il;
  } ov_t;

  typedef struct packed {
    logic rdy;
    logic z;
    logic lt;
    ov_t  ea;
    ov_t  eb;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, alu_zero, alu_lt, mem_ready;

  logic       req_a, we_a, mas_a, irw_a, pcw_a, pcs_a, as_a, aow_a, rw_a, wbs_a, dn_a, il_a;
  logic [1:0] bs_a;
  logic [3:0] ac_a;
  logic [2:0] st_a;
  logic       req_b, we_b, mas_b, irw_b, pcw_b, pcs_b, as_b, aow_b, rw_b, wbs_b, dn_b, il_b;
  logic [1:0] bs_b;
  logic [3:0] ac_b;
  logic [2:0] st_b;

  ov_t obs_a, obs_b;
  assign obs_a = {st_a, req_a, we_a, mas_a, irw_a, pcw_a, pcs_a, as_a, bs_a, ac_a,
                  aow_a, rw_a, wbs_a, dn_a, il_a};
  assign obs_b = {st_b, req_b, we_b, mas_b, irw_b, pcw_b, pcs_b, as_b, bs_b, ac_b,
                  aow_b, rw_b, wbs_b, dn_b, il_b};

  always #5 clk = ~clk;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .mem_req(req_a), .mem_we(we_a), .mem_addr_sel(mas_a), .ir_we(irw_a),
    .pc_we(pcw_a), .pc_sel(pcs_a), .alu_a_sel(as_a), .alu_b_sel(bs_a),
    .alu_ctrl(ac_a), .alu_out_we(aow_a), .reg_we(rw_a), .wb_sel(wbs_a),
    .instr_done(dn_a), .illegal(il_a), .state_dbg(st_a)
  );

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .mem_req(req_b), .mem_we(we_b), .mem_addr_sel(mas_b), .ir_we(irw_b),
    .pc_we(pcw_b), .pc_sel(pcs_b), .alu_a_sel(as_b), .alu_b_sel(bs_b),
    .alu_ctrl(ac_b), .alu_out_we(aow_b), .reg_we(rw_b), .wb_sel(wbs_b),
    .instr_done(dn_b), .illegal(il_b), .state_dbg(st_b)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic cur_z, cur_lt;
  rec_t q[$];

  // Expected output vectors, one per state as the controller defines them.
  function automatic ov_t e_zero();
    ov_t e = '0;
    return e;
  endfunction
  function automatic ov_t e_fetch(input logic rdy);
    ov_t e = '0;
    e.st = 3'd0; e.req = 1'b1; e.bs = 2'd2; e.ac = 4'd0;
    e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction
  function automatic ov_t e_decode(input logic dn);
    ov_t e = '0;
    e.st = 3'd1; e.dn = dn;
    return e;
  endfunction
  function automatic ov_t e_exec(input logic [1:0] bs, input logic [3:0] ac);
    ov_t e = '0;
    e.st = 3'd2; e.as = 1'b1; e.aow = 1'b1; e.bs = bs; e.ac = ac;
    return e;
  endfunction
  function automatic ov_t e_mem(input logic we, input logic rdy);
    ov_t e = '0;
    e.st = 3'd3; e.req = 1'b1; e.mas = 1'b1; e.we = we; e.dn = we & rdy;
    return e;
  endfunction
  function automatic ov_t e_wb(input logic wbs);
    ov_t e = '0;
    e.st = 3'd4; e.rw = 1'b1; e.wbs = wbs; e.dn = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_br(input logic taken);
    ov_t e = '0;
    e.st = 3'd5; e.as = 1'b1; e.bs = 2'd0; e.ac = 4'd1; e.dn = 1'b1;
    e.pcw = taken; e.pcs = taken;
    return e;
  endfunction
  function automatic ov_t e_trap();
    ov_t e = '0;
    e.st = 3'd7; e.il = 1'b1;
    return e;
  endfunction

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt);
    opcode = op; funct3 = f3; funct7_5 = f7; cur_z = z; cur_lt = lt;
  endtask

  task automatic push2(input logic rdy, input ov_t ea, input ov_t eb);
    rec_t r;
    r.rdy = rdy; r.z = cur_z; r.lt = cur_lt; r.ea = ea; r.eb = eb;
    q.push_back(r);
  endtask

  task automatic push(input logic rdy, input ov_t e);
    push2(rdy, e, e);
  endtask

  task automatic cmp(input string tag, input ov_t ea, input ov_t eb);
    tests++;
    assert (obs_a === ea) else begin
      fails++;
      $error("FAIL %s cyc=%0d dut(trap) observed=%h expected=%h", tag, cyc, obs_a, ea);
    end
    tests++;
    assert (obs_b === eb) else begin
      fails++;
      $error("FAIL %s cyc=%0d dut(nop) observed=%h expected=%h", tag, cyc, obs_b, eb);
    end
  endtask

  // Pops each queued record, drives its inputs, compares at the falling edge.
  task automatic drain(input string tag);
    rec_t r;
    cyc = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      mem_ready = r.rdy; alu_zero = r.z; alu_lt = r.lt;
      cyc++;
      @(negedge clk);
      cmp(tag, r.ea, r.eb);
      @(posedge clk);
      #1;
    end
  endtask

  // Compares the head record right now, without waiting for a clock edge.
  task automatic check_now(input string tag);
    rec_t r;
    r = q.pop_front();
    cyc = 0;
    cmp(tag, r.ea, r.eb);
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [1:0] bs, input logic [3:0] ac);
    instr(op, f3, f7, 1'b0, 1'b0);
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_exec(bs, ac));
    push(1'b1, e_wb(1'b0));
    drain(tag);
  endtask

  task automatic branch_instr(input string tag, input logic [2:0] f3, input logic z,
                              input logic lt, input logic taken);
    instr(7'b1100011, f3, 1'b0, z, lt);
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_br(taken));
    drain(tag);
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    #1;
    push(1'b1, e_zero());
    check_now({tag, "_now"});
    push(1'b1, e_zero());
    drain(tag);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; alu_lt = 1'b0;
    instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);

    // Held in reset: every output low, state FETCH encoding.
    push(1'b1, e_zero());
    push(1'b1, e_zero());
    drain("reset");
    rst = 1'b0;

    // addi with zero-wait memory: FETCH, DECODE, EXEC, WB.
    alu_instr("addi", 7'b0010011, 3'b000, 1'b0, 2'd1, 4'd0);

    // lw with three wait cycles in FETCH and in MEM: 11 cycles.
    instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, e_fetch(1'b0));
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_exec(2'd1, 4'd0));
    for (int i = 0; i < 3; i++) push(1'b0, e_mem(1'b0, 1'b0));
    push(1'b1, e_mem(1'b0, 1'b1));
    push(1'b1, e_wb(1'b1));
    drain("lw_wait");

    // sw: retires from MEM, no register write.
    instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_exec(2'd1, 4'd0));
    push(1'b1, e_mem(1'b1, 1'b1));
    push(1'b1, e_fetch(1'b1));
    drain("sw");
    // sw above already consumed one fetch of the next instruction; finish it as addi.
    instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_exec(2'd1, 4'd0));
    push(1'b1, e_wb(1'b0));
    drain("after_sw");

    // Branches.
    branch_instr("beq_taken",  3'b000, 1'b1, 1'b0, 1'b1);
    branch_instr("beq_not",    3'b000, 1'b0, 1'b0, 1'b0);
    branch_instr("bne_not",    3'b001, 1'b1, 1'b0, 1'b0);
    branch_instr("bne_taken",  3'b001, 1'b0, 1'b1, 1'b1);
    branch_instr("blt_taken",  3'b100, 1'b0, 1'b1, 1'b1);
    branch_instr("blt_not",    3'b100, 1'b1, 1'b0, 1'b0);

    // ALU mapping.
    alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 2'd0, 4'd1);
    alu_instr("r_add",  7'b0110011, 3'b000, 1'b0, 2'd0, 4'd0);
    alu_instr("i_add7", 7'b0010011, 3'b000, 1'b1, 2'd1, 4'd0);
    alu_instr("r_and",  7'b0110011, 3'b111, 1'b0, 2'd0, 4'd2);
    alu_instr("r_or",   7'b0110011, 3'b110, 1'b0, 2'd0, 4'd3);
    alu_instr("r_xor",  7'b0110011, 3'b100, 1'b0, 2'd0, 4'd4);
    alu_instr("r_slt",  7'b0110011, 3'b010, 1'b0, 2'd0, 4'd5);
    alu_instr("r_sll",  7'b0110011, 3'b001, 1'b0, 2'd0, 4'd6);
    alu_instr("r_srl",  7'b0110011, 3'b101, 1'b0, 2'd0, 4'd7);
    alu_instr("r_sra",  7'b0110011, 3'b101, 1'b1, 2'd0, 4'd8);
    alu_instr("i_srai", 7'b0010011, 3'b101, 1'b1, 2'd1, 4'd8);

    // Reset asserted while waiting in MEM: request drops at once.
    instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b0, e_exec(2'd1, 4'd0));
    push(1'b0, e_mem(1'b0, 1'b0));
    drain("lw_to_mem");
    rst_pulse("rst_mid_mem");
    push(1'b1, e_fetch(1'b1));
    push(1'b1, e_decode(1'b0));
    push(1'b1, e_exec(2'd1, 4'd0));
    push(1'b1, e_mem(1'b0, 1'b1));
    push(1'b1, e_wb(1'b1));
    drain("lw_after_rst");

    // Unsupported funct3 on ALU and branch opcodes.
    instr(7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0);
    push2(1'b1, e_fetch(1'b1), e_fetch(1'b1));
    push2(1'b1, e_decode(1'b0), e_decode(1'b1));
    push2(1'b1, e_trap(), e_fetch(1'b1));
    push2(1'b1, e_trap(), e_decode(1'b1));
    drain("ill_sltu");
    rst_pulse("rst_ill1");

    instr(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1);
    push2(1'b1, e_fetch(1'b1), e_fetch(1'b1));
    push2(1'b1, e_decode(1'b0), e_decode(1'b1));
    push2(1'b1, e_trap(), e_fetch(1'b1));
    drain("ill_br");
    rst_pulse("rst_ill2");

    // jal opcode: trap held for 10 cycles; the NOP variant keeps retiring.
    instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    push2(1'b1, e_fetch(1'b1), e_fetch(1'b1));
    push2(1'b1, e_decode(1'b0), e_decode(1'b1));
    for (int i = 0; i < 10; i++)
      push2(1'b1, e_trap(), (i % 2 == 0) ? e_fetch(1'b1) : e_decode(1'b1));
    drain("ill_jal");
    rst_pulse("rst_in_trap");

    // Restart after leaving TRAP.
    alu_instr("addi_restart", 7'b0010011, 3'b000, 1'b0, 2'd1, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
